// File: rtl/fpu_issue_queue_if.sv
// Issue-side and dispatch-side bundle between the integer core, the FPU issue queue and rvfpm.
interface fpu_issue_queue_if #(
    parameter int X_ID_WIDTH = 4,
    parameter int XLEN       = 32
);
    logic                  issue_valid;
    logic                  issue_ready;
    logic [31:0]           issue_instr;
    logic [X_ID_WIDTH-1:0] issue_id;
    logic [XLEN-1:0]       issue_rs1;
    logic                  issue_accept;

    logic                  fpu_stall;
    logic                  fpu_enable;
    logic [31:0]           fpu_instruction;
    logic [X_ID_WIDTH-1:0] fpu_id;
    logic [XLEN-1:0]       fpu_data_fromXReg;

    // master: core + rvfpm side; slave: the issue queue
    modport master (
        output issue_valid, issue_instr, issue_id, issue_rs1, fpu_stall,
        input  issue_ready, issue_accept, fpu_enable, fpu_instruction, fpu_id, fpu_data_fromXReg
    );

    modport slave (
        input  issue_valid, issue_instr, issue_id, issue_rs1, fpu_stall,
        output issue_ready, issue_accept, fpu_enable, fpu_instruction, fpu_id, fpu_data_fromXReg
    );
endinterface

// File: rtl/fpu_issue_queue.sv
// RV32F issue queue in front of rvfpm; decodes and rejects non-F instructions, buffers the rest.
// Latency: one edge from accept to fpu_enable (no bypass); stalls hold the FIFO, full drops issue_ready.
module fpu_issue_queue #(
    parameter int DEPTH      = 4,
    parameter int X_ID_WIDTH = 4,
    parameter int XLEN       = 32
) (
    input  logic                   ck,
    input  logic                   rst,
    fpu_issue_queue_if.slave       bus,
    input  logic                   flush,
    output logic [$clog2(DEPTH):0] count,
    output logic [7:0]             reject_count
);
    localparam int PW = $clog2(DEPTH);

    typedef struct packed {
        logic [31:0]           instr;
        logic [X_ID_WIDTH-1:0] id;
        logic [XLEN-1:0]       rs1;
    } entry_t;

    entry_t          mem [DEPTH];
    entry_t          head;
    logic [PW-1:0]   wrPtr;
    logic [PW-1:0]   rdPtr;
    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [1:0]      fmt;
    logic            decodeOk;
    logic            handshake;
    logic            push;
    logic            reject;
    logic            pop;

    // Single-precision only: width field for loads/stores, fmt field for arithmetic
    always_comb begin
        opcode   = bus.issue_instr[6:0];
        funct3   = bus.issue_instr[14:12];
        fmt      = bus.issue_instr[26:25];
        decodeOk = 1'b0;
        case (opcode)
            7'b0000111, 7'b0100111:                          decodeOk = (funct3 == 3'b010);
            7'b1010011, 7'b1000011, 7'b1000111,
            7'b1001011, 7'b1001111:                          decodeOk = (fmt == 2'b00);
            default:                                         decodeOk = 1'b0;
        endcase
    end

    assign bus.issue_accept = decodeOk;
    assign bus.issue_ready  = (count < (PW+1)'(DEPTH)) && !flush && !rst;
    assign handshake        = bus.issue_valid && bus.issue_ready;
    assign push             = handshake && decodeOk;
    assign reject           = handshake && !decodeOk;
    assign pop              = (count != '0) && !bus.fpu_stall && !flush;
    assign head             = mem[rdPtr];

    always_ff @(posedge ck) begin
        if (push) begin
            mem[wrPtr] <= '{instr: bus.issue_instr, id: bus.issue_id, rs1: bus.issue_rs1};
        end
    end

    always_ff @(posedge ck) begin
        if (rst) begin
            count                 <= '0;
            wrPtr                 <= '0;
            rdPtr                 <= '0;
            reject_count          <= '0;
            bus.fpu_enable        <= 1'b0;
            bus.fpu_instruction   <= '0;
            bus.fpu_id            <= '0;
            bus.fpu_data_fromXReg <= '0;
        end else if (flush) begin
            count          <= '0;
            wrPtr          <= '0;
            rdPtr          <= '0;
            bus.fpu_enable <= 1'b0;
        end else begin
            if (push) begin
                wrPtr <= wrPtr + PW'(1);
            end
            if (pop) begin
                bus.fpu_enable        <= 1'b1;
                bus.fpu_instruction   <= head.instr;
                bus.fpu_id            <= head.id;
                bus.fpu_data_fromXReg <= head.rs1;
                rdPtr                 <= rdPtr + PW'(1);
            end else begin
                bus.fpu_enable <= 1'b0;
            end
            case ({push, pop})
                2'b10:   count <= count + (PW+1)'(1);
                2'b01:   count <= count - (PW+1)'(1);
                default: count <= count;
            endcase
            if (reject && (reject_count != 8'hFF)) begin
                reject_count <= reject_count + 8'd1;
            end
        end
    end
endmodule

// File: tb/tb_fpu_issue_queue.sv
// Scoreboard bench for fpu_issue_queue: queue-based reference model feeds expected dispatches to a monitor.
module tb_fpu_issue_queue;
    localparam int DEPTH = 4;
    localparam int XW    = 4;
    localparam int XLEN  = 32;

    logic                   ck = 1'b0;
    logic                   rst;
    logic                   flush;
    logic [$clog2(DEPTH):0] count;
    logic [7:0]             reject_count;

    fpu_issue_queue_if #(.X_ID_WIDTH(XW), .XLEN(XLEN)) bus ();

    fpu_issue_queue #(.DEPTH(DEPTH), .X_ID_WIDTH(XW), .XLEN(XLEN)) dut (
        .ck(ck), .rst(rst), .bus(bus), .flush(flush),
        .count(count), .reject_count(reject_count)
    );

    always #5 ck = ~ck;

    typedef struct {
        logic [31:0]     instr;
        logic [XW-1:0]   id;
        logic [XLEN-1:0] rs1;
    } item_t;

    item_t modelQ[$];
    item_t expQ[$];
    item_t last;
    int    modelRej;
    bit    started;
    int    total;
    int    passed;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // RV32F acceptance rules expressed as a table of legal opcode classes
    function automatic bit isLegal(input logic [31:0] w);
        logic [6:0] op;
        logic [2:0] f3;
        logic [1:0] fm;
        op = w[6:0];
        f3 = w[14:12];
        fm = w[26:25];
        if (op == 7'h07 || op == 7'h27) return f3 == 3'd2;
        if (op inside {7'h53, 7'h43, 7'h47, 7'h4B, 7'h4F}) return fm == 2'd0;
        return 1'b0;
    endfunction

    // One clock of stimulus: drive, check combinational outputs and registered state, advance the model
    task automatic step(input bit v, input logic [31:0] ins, input logic [XW-1:0] id,
                        input logic [XLEN-1:0] rs1, input bit stall, input bit fl, input bit r,
                        output bit hs);
        bit    expReady;
        bit    doPop;
        item_t head;
        @(negedge ck);
        bus.issue_valid = v;
        bus.issue_instr = ins;
        bus.issue_id    = id;
        bus.issue_rs1   = rs1;
        bus.fpu_stall   = stall;
        flush           = fl;
        rst             = r;
        #1;
        expReady = !r && !fl && (modelQ.size() < DEPTH);
        hs       = 1'b0;
        if (started) begin
            check("issue_ready", 64'(bus.issue_ready), 64'(expReady));
            if (v) check("issue_accept", 64'(bus.issue_accept), 64'(isLegal(ins)));
            check("count", 64'(count), 64'(modelQ.size()));
            check("reject_count", 64'(reject_count), 64'(modelRej));
        end
        if (r) begin
            modelQ.delete();
            modelRej = 0;
            last     = '{instr: '0, id: '0, rs1: '0};
            started  = 1'b1;
        end else if (fl) begin
            modelQ.delete();
        end else begin
            doPop = (modelQ.size() > 0) && !stall;
            if (doPop) head = modelQ.pop_front();
            if (v && expReady) begin
                hs = 1'b1;
                if (isLegal(ins)) modelQ.push_back('{instr: ins, id: id, rs1: rs1});
                else if (modelRej < 255) modelRej++;
            end
            if (doPop) expQ.push_back(head);
        end
    endtask

    task automatic idle(input int n, input bit stall);
        bit hs;
        for (int i = 0; i < n; i++) step(1'b0, '0, '0, '0, stall, 1'b0, 1'b0, hs);
    endtask

    // Monitor: every registered dispatch must match the head of the scoreboard, idle cycles must hold data
    initial begin
        item_t e;
        forever begin
            @(negedge ck);
            if (started) begin
                if (bus.fpu_enable === 1'b1 && expQ.size() > 0) begin
                    e = expQ.pop_front();
                    check("dispatch_instr", 64'(bus.fpu_instruction), 64'(e.instr));
                    check("dispatch_id", 64'(bus.fpu_id), 64'(e.id));
                    check("dispatch_rs1", 64'(bus.fpu_data_fromXReg), 64'(e.rs1));
                    last = e;
                end else begin
                    check("fpu_enable", 64'(bus.fpu_enable), 64'(expQ.size() > 0));
                    if (expQ.size() > 0) void'(expQ.pop_front());
                    check("hold_instr", 64'(bus.fpu_instruction), 64'(last.instr));
                    check("hold_id", 64'(bus.fpu_id), 64'(last.id));
                    check("hold_rs1", 64'(bus.fpu_data_fromXReg), 64'(last.rs1));
                end
            end
        end
    end

    initial begin
        bit          hs;
        logic [31:0] rnd;
        logic [31:0] ins;
        logic [6:0]  ops [9];
        ops = '{7'h07, 7'h27, 7'h53, 7'h43, 7'h47, 7'h4B, 7'h4F, 7'h33, 7'h13};
        total = 0; passed = 0; modelRej = 0; started = 1'b0;
        last = '{instr: '0, id: '0, rs1: '0};
        bus.issue_valid = 1'b0; bus.issue_instr = '0; bus.issue_id = '0; bus.issue_rs1 = '0;
        bus.fpu_stall = 1'b0; flush = 1'b0; rst = 1'b1;

        step(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b1, hs);
        step(1'b1, 32'h00208053, 4'd1, 32'h1, 1'b0, 1'b0, 1'b1, hs);

        // single fadd.s
        step(1'b1, 32'h00208053, 4'd3, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0, hs);
        idle(3, 1'b0);

        // integer add and fadd.d are rejected
        step(1'b1, 32'h003100B3, 4'd1, 32'h11, 1'b0, 1'b0, 1'b0, hs);
        step(1'b1, 32'h02208053, 4'd2, 32'h22, 1'b0, 1'b0, 1'b0, hs);
        idle(2, 1'b0);

        // fill under stall, fifth held until space frees
        for (int i = 0; i < 5; i++) step(1'b1, 32'h00012087, XW'(i), 32'h100 + i, 1'b1, 1'b0, 1'b0, hs);
        hs = 1'b0;
        for (int k = 0; k < 10 && !hs; k++) step(1'b1, 32'h00012087, 4'd4, 32'h104, 1'b0, 1'b0, 1'b0, hs);
        idle(6, 1'b0);

        // push and pop in the same cycle at count=2
        step(1'b1, 32'h00012087, 4'd5, 32'h205, 1'b1, 1'b0, 1'b0, hs);
        step(1'b1, 32'h00012087, 4'd6, 32'h206, 1'b1, 1'b0, 1'b0, hs);
        step(1'b1, 32'h00012087, 4'd7, 32'h207, 1'b0, 1'b0, 1'b0, hs);
        idle(5, 1'b0);

        // flush with a concurrent issue
        for (int i = 8; i < 11; i++) step(1'b1, 32'h00012087, XW'(i), 32'h300 + i, 1'b1, 1'b0, 1'b0, hs);
        step(1'b1, 32'h003100B3, 4'd11, 32'h30B, 1'b0, 1'b1, 1'b0, hs);
        idle(4, 1'b0);

        // reset while dispatching
        for (int i = 12; i < 15; i++) step(1'b1, 32'h00012087, XW'(i), 32'h400 + i, 1'b1, 1'b0, 1'b0, hs);
        idle(1, 1'b0);
        step(1'b1, 32'h00208053, 4'd13, 32'h4FF, 1'b0, 1'b0, 1'b1, hs);
        idle(4, 1'b0);
        step(1'b1, 32'h00208053, 4'd15, 32'h40F, 1'b0, 1'b0, 1'b0, hs);
        idle(3, 1'b0);

        // randomized traffic with occasional flush and reset
        for (int c = 0; c < 600; c++) begin
            rnd = $urandom();
            ins = {rnd[31:7], ops[$urandom_range(0, 8)]};
            if ($urandom_range(0, 1) == 1) begin
                ins[14:12] = 3'b010;
                ins[26:25] = 2'b00;
            end
            step($urandom_range(0, 3) != 0, ins, XW'($urandom()), $urandom(),
                 $urandom_range(0, 9) < 3, $urandom_range(0, 39) == 0,
                 $urandom_range(0, 99) == 0, hs);
        end
        idle(DEPTH + 4, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
